step_pulse_decoder: RTL and testbench

- Receiving end of the step/dir interface driven by jas_control.
- Decodes STEP/DIR into a signed position, counts the steps of one commanded move, and measures the clock-cycle interval between consecutive step pulses.
- Flags overspeed (interval shorter than a programmed minimum) and stall (no pulse within TIMEOUT).
- Used in-system as a loop-back monitor on the motor outputs, and as the checker in pulse-generator benches.

---
 rtl/step_decoder_pkg.sv | 19 +
 rtl/step_sync_edge.sv | 35 +++
 rtl/step_pulse_decoder.sv | 196 +++++++++++++++++++
 tb/tb_step_pulse_decoder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_decoder_pkg.sv
// Shared types and constants for the step/dir pulse decoder.
`timescale 1ns/1ps
package step_decoder_pkg;

    // Default width of position, step count and period counters.
    localparam int DEFAULT_CNT_W = 32;

    // All-ones pattern; counters slice it to their width to find saturation.
    localparam logic [63:0] SAT_ONES = '1;

    // Move-measurement FSM states.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FIRST = 2'd1,
        ST_MEASURE    = 2'd2,
        ST_DONE       = 2'd3
    } state_t;

endpackage

// File: rtl/step_sync_edge.sv
// Synchronizes asynchronous STEP/DIR into the clk domain and flags STEP rising edges.
// DIR travels through an identical chain, so o_dir_s is aligned with o_edge.
`timescale 1ns/1ps
module step_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_step,
    input  logic i_dir,
    output logic o_edge,
    output logic o_dir_s
);

    logic [SYNC_STAGES-1:0] r_step_sync;
    logic [SYNC_STAGES-1:0] r_dir_sync;
    logic                   r_step_prev;

    // Shift both inputs through matching synchronizer chains; remember last synced STEP.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_step_sync <= '0;
            r_dir_sync  <= '0;
            r_step_prev <= 1'b0;
        end else begin
            r_step_sync <= {r_step_sync[SYNC_STAGES-2:0], i_step};
            r_dir_sync  <= {r_dir_sync[SYNC_STAGES-2:0], i_dir};
            r_step_prev <= r_step_sync[SYNC_STAGES-1];
        end
    end

    assign o_edge  = r_step_sync[SYNC_STAGES-1] & ~r_step_prev;
    assign o_dir_s = r_dir_sync[SYNC_STAGES-1];

endmodule

// File: rtl/step_pulse_decoder.sv
// Step/dir receiver: tracks signed position, measures one commanded move
// (step count, inter-step period, overspeed and stall detection).
//
// Output strobes: period_valid and done are one-cycle strobes with no
// backpressure; a consumer must sample them on the cycle they are high.
// state_dbg mirrors the FSM state register for observation.
`timescale 1ns/1ps
module step_pulse_decoder
    import step_decoder_pkg::*;
#(
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_in,
    input  logic             dir_in,
    input  logic             clear,
    input  logic             start,
    input  logic [CNT_W-1:0] steps_target,
    input  logic [CNT_W-1:0] min_period,
    output logic [CNT_W-1:0] position,
    output logic [CNT_W-1:0] step_count,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             busy,
    output logic             done,
    output logic             overspeed,
    output logic             timeout,
    output logic [1:0]       state_dbg
);

    localparam logic [CNT_W-1:0] W_SAT     = SAT_ONES[CNT_W-1:0];
    localparam logic [CNT_W-1:0] W_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] W_ONE     = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_position;
    logic [CNT_W-1:0] r_step_count;
    logic [CNT_W-1:0] r_period;
    logic             r_period_valid;
    logic             r_overspeed;
    logic             r_timeout;
    logic [CNT_W-1:0] r_interval;
    logic [CNT_W-1:0] r_target;
    logic [CNT_W-1:0] r_min_period;

    logic             w_edge;
    logic             w_dir_s;
    logic             w_busy;
    logic             w_arm;
    logic             w_first;
    logic             w_step;
    logic             w_stall;
    logic [CNT_W-1:0] w_count_inc;

    step_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .i_step (step_in),
        .i_dir  (dir_in),
        .o_edge (w_edge),
        .o_dir_s(w_dir_s)
    );

    assign w_busy      = (r_state == ST_WAIT_FIRST) || (r_state == ST_MEASURE);
    assign w_count_inc = r_step_count + W_ONE;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic plus the datapath control strobes for this cycle.
    // An edge wins over a stall that matures in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_arm        = 1'b0;
        w_first      = 1'b0;
        w_step       = 1'b0;
        w_stall      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_arm        = 1'b1;
                    w_state_next = (steps_target == '0) ? ST_DONE : ST_WAIT_FIRST;
                end
            end
            ST_WAIT_FIRST: begin
                if (w_edge) begin
                    w_first      = 1'b1;
                    w_state_next = (r_target == W_ONE) ? ST_DONE : ST_MEASURE;
                end else if (r_interval >= W_TIMEOUT) begin
                    w_stall      = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_MEASURE: begin
                if (w_edge) begin
                    w_step = 1'b1;
                    if (w_count_inc == r_target) begin
                        w_state_next = ST_DONE;
                    end
                end else if (r_interval >= W_TIMEOUT) begin
                    w_stall      = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Running position: follows every edge in any state; clear takes priority.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_position <= '0;
        end else if (clear) begin
            r_position <= '0;
        end else if (w_edge) begin
            r_position <= w_dir_s ? (r_position + W_ONE) : (r_position - W_ONE);
        end
    end

    // Interval counter: zeroed on arm, reloaded to 1 by an edge, saturating count while busy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_interval <= '0;
        end else if (w_arm) begin
            r_interval <= '0;
        end else if (w_edge) begin
            r_interval <= W_ONE;
        end else if (w_busy && (r_interval != W_SAT)) begin
            r_interval <= r_interval + W_ONE;
        end
    end

    // Move measurement: latch parameters on arm, count steps, report period, set sticky flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_target       <= '0;
            r_min_period   <= '0;
            r_step_count   <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_overspeed    <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_period_valid <= 1'b0;
            if (w_arm) begin
                r_target     <= steps_target;
                r_min_period <= min_period;
                r_step_count <= '0;
                r_overspeed  <= 1'b0;
                r_timeout    <= 1'b0;
            end
            if (w_first) begin
                r_step_count <= W_ONE;
            end
            if (w_step) begin
                r_step_count   <= w_count_inc;
                r_period       <= r_interval;
                r_period_valid <= 1'b1;
                if ((r_min_period != '0) && (r_interval < r_min_period)) begin
                    r_overspeed <= 1'b1;
                end
            end
            if (w_stall) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign position     = r_position;
    assign step_count   = r_step_count;
    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign busy         = w_busy;
    assign done         = (r_state == ST_DONE);
    assign overspeed    = r_overspeed;
    assign timeout      = r_timeout;
    assign state_dbg    = r_state;

endmodule

// File: tb/tb_step_pulse_decoder.sv
// Self-checking bench for step_pulse_decoder: expected periods are queued as
// pulses are driven and compared when period_valid fires.
`timescale 1ns/1ps
module tb_step_pulse_decoder;

  localparam int CNT_W = 32;
  localparam int TMO   = 200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic             step_in = 1'b0;
  logic             dir_in = 1'b0;
  logic             clear = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] steps_target = '0;
  logic [CNT_W-1:0] min_period = '0;
  logic [CNT_W-1:0] position;
  logic [CNT_W-1:0] step_count;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             busy;
  logic             done;
  logic             overspeed;
  logic             timeout;
  logic [1:0]       state_dbg;

  step_pulse_decoder #(
    .CNT_W(CNT_W),
    .SYNC_STAGES(2),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .step_in(step_in),
    .dir_in(dir_in),
    .clear(clear),
    .start(start),
    .steps_target(steps_target),
    .min_period(min_period),
    .position(position),
    .step_count(step_count),
    .period(period),
    .period_valid(period_valid),
    .busy(busy),
    .done(done),
    .overspeed(overspeed),
    .timeout(timeout),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [CNT_W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int pv_cnt = 0;
  int rise_cyc = 0;
  logic [CNT_W-1:0] exp_pos = '0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expected period on every strobe, records done pulses.
  always @(negedge clk) begin
    if (reset && period_valid) begin
      pv_cnt++;
      if (exp_q.size() > 0) begin
        check("period", 64'(period), 64'(exp_q.pop_front()));
      end else begin
        check("period_unexpected_qsize", 64'(exp_q.size()), 64'd1);
      end
    end
    if (reset && done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_move(input logic [CNT_W-1:0] target, input logic [CNT_W-1:0] minp);
    steps_target = target;
    min_period   = minp;
    start        = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One STEP pulse, 3 cycles high; returns 'gap' cycles after the rise.
  task automatic step_pulse(input logic d, input int gap);
    step_in  = 1'b1;
    dir_in   = d;
    rise_cyc = cyc;
    exp_pos  = d ? exp_pos + 1 : exp_pos - 1;
    repeat (3) tick();
    step_in = 1'b0;
    repeat (gap - 3) tick();
  endtask

  task automatic wait_done(input int base, input int max_cyc);
    int n;
    n = 0;
    while (done_cnt == base && n < max_cyc) begin
      tick();
      n++;
    end
    check("done_count", 64'(done_cnt), 64'(base + 1));
  endtask

  // ---------------- stimulus ----------------
  int base;
  int g;
  int r2;
  int pv_base;
  int ov_gaps[5] = '{60, 60, 40, 60, 20};

  initial begin
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("rst_position", 64'(position), 64'd0);
    check("rst_step_count", 64'(step_count), 64'd0);
    check("rst_period", 64'(period), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_flags", 64'({overspeed, timeout, period_valid}), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);

    // Nominal move: 15 steps, 100 cycles apart.
    base = done_cnt;
    pv_base = pv_cnt;
    start_move(15, 0);
    check("nom_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 15; i++) begin
      if (i > 0) exp_q.push_back(CNT_W'(100));
      step_pulse(1'b1, 100);
      if (i == 0) check("nom_first_count", 64'(step_count), 64'd1);
    end
    wait_done(base, 50);
    check("nom_pv_count", 64'(pv_cnt - pv_base), 64'd14);
    check("nom_done_latency", 64'(done_cyc - rise_cyc), 64'd3);
    check("nom_step_count", 64'(step_count), 64'd15);
    check("nom_position", 64'(position), 64'(exp_pos));
    check("nom_busy_after", 64'(busy), 64'd0);

    // Overspeed: min 50, spacing 60,60,40,60.
    base = done_cnt;
    start_move(5, 50);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) exp_q.push_back(CNT_W'(ov_gaps[i-1]));
      step_pulse(1'b1, ov_gaps[i]);
      if (i == 2) check("ov_before", 64'(overspeed), 64'd0);
      if (i == 3) check("ov_set", 64'(overspeed), 64'd1);
    end
    wait_done(base, 50);
    check("ov_sticky", 64'(overspeed), 64'd1);
    check("ov_step_count", 64'(step_count), 64'd5);
    check("ov_position", 64'(position), 64'(exp_pos));

    // Direction and wrap.
    clear = 1'b1;
    tick();
    clear   = 1'b0;
    exp_pos = '0;
    check("clr_position", 64'(position), 64'd0);
    step_pulse(1'b0, 10);
    step_pulse(1'b0, 10);
    check("wrap_position", 64'(position), 64'h0000_0000_FFFF_FFFE);
    check("idle_step_count", 64'(step_count), 64'd5);

    // Same-cycle clear and edge inside a move.
    base = done_cnt;
    start_move(3, 0);
    step_pulse(1'b1, 20);
    exp_q.push_back(CNT_W'(20));
    step_in = 1'b1;
    dir_in  = 1'b1;
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear   = 1'b0;
    step_in = 1'b0;
    exp_pos = '0;
    repeat (17) tick();
    check("coll_position", 64'(position), 64'(exp_pos));
    check("coll_step_count", 64'(step_count), 64'd2);
    exp_q.push_back(CNT_W'(20));
    step_pulse(1'b1, 20);
    wait_done(base, 50);
    check("coll_final_count", 64'(step_count), 64'd3);
    check("coll_final_pos", 64'(position), 64'(exp_pos));

    // Timeout: target 5, only 2 pulses.
    base = done_cnt;
    start_move(5, 0);
    step_pulse(1'b1, 100);
    exp_q.push_back(CNT_W'(100));
    step_pulse(1'b1, 100);
    r2 = rise_cyc;
    wait_done(base, 400);
    check("tmo_latency", 64'(done_cyc - r2), 64'(3 + TMO));
    check("tmo_flag", 64'(timeout), 64'd1);
    check("tmo_step_count", 64'(step_count), 64'd2);
    tick();
    check("tmo_busy", 64'(busy), 64'd0);

    // Zero target: DONE straight from IDLE.
    start_move(0, 0);
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    check("zero_state", 64'(state_dbg), 64'd3);
    check("zero_timeout_cleared", 64'(timeout), 64'd0);
    tick();
    check("zero_done_once", 64'(done), 64'd0);
    check("zero_idle", 64'(state_dbg), 64'd0);

    // Re-start while busy is ignored: target stays 4.
    base = done_cnt;
    start_move(4, 0);
    check("rs_busy", 64'(busy), 64'd1);
    start_move(9, 0);
    g = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) exp_q.push_back(CNT_W'(g));
      g = (i == 3) ? 20 : int'($urandom_range(25, 40));
      step_pulse(1'b1, g);
    end
    wait_done(base, 50);
    check("rs_step_count", 64'(step_count), 64'd4);
    check("rs_position", 64'(position), 64'(exp_pos));

    // Reset mid-move with an edge landing in the reset cycle.
    base = done_cnt;
    pv_base = pv_cnt;
    start_move(10, 0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) exp_q.push_back(CNT_W'(30));
      step_pulse(1'b1, 30);
    end
    check("mid_step_count", 64'(step_count), 64'd3);
    step_in = 1'b1;
    tick();
    tick();
    reset   = 1'b0;
    step_in = 1'b0;
    tick();
    reset = 1'b1;
    exp_pos = '0;
    check("mr_position", 64'(position), 64'(exp_pos));
    check("mr_step_count", 64'(step_count), 64'd0);
    check("mr_busy", 64'(busy), 64'd0);
    repeat (50) tick();
    check("mr_position_later", 64'(position), 64'(exp_pos));
    check("mr_no_done", 64'(done_cnt), 64'(base));
    check("mr_pv_count", 64'(pv_cnt - pv_base), 64'd2);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
